countdown_timer_ctrl: RTL
=========================

# countdown_timer_ctrl

- Controls a seconds-resolution countdown timer on the board's 50 MHz clock.
- Contains its own gated prescaler that produces the 1 Hz time base. Unlike the free-running divider, the prescaler advances only while the timer runs, so pause and resume keep the fraction of a second already counted.
- Sequences the load/start/pause/clear commands from the (debounced) front-panel logic and drives the seconds display and the end-of-count indication.

## Interface
- TICK_DIV, 50000000: clock cycles per 1-second tick (set small, e.g. 4, in simulation); must be ≥ 2.
- CNT_W, 8: width of the seconds counter.
- clk_50mHz  in  1  system clock, 50 MHz.
- rst_n  in  1  reset; asynchronous, active-low.
- load_val  in  CNT_W  start value in seconds, sampled on an accepted start-with-reload.
- start  in  1  one-cycle command pulse: start, resume or restart.
- pause  in  1  one-cycle command pulse: pause.
- clear  in  1  one-cycle command pulse: abort to idle.
- remain  out  CNT_W  seconds remaining.
- tick_1Hz  out  1  one-cycle pulse at each elapsed second while running.
- done  out  1  one-cycle pulse when the count reaches 0.
- running  out  1  high exactly while the state is RUN.
- state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.

## Operation
- Internal prescaler `pre`, width ceil(log2(TICK_DIV)):
  - In RUN, increments every cycle.
  - When `pre` == TICK_DIV-1 in RUN: `pre` goes to 0 and a tick event occurs.
  - Held in PAUSE.
  - Forced to 0 in IDLE and DONE, and on any reload.
- Tick event:
  - tick_1Hz is driven high the next cycle and remain decrements in that same next cycle.
  - If remain was 1, then in that next cycle remain = 0, done = 1 and state = DONE.
- Command priority within one cycle is clear > start > pause. Commands not listed for a state are ignored.
- IDLE:
  - start with load_val ≠ 0 → RUN; remain ← load_val; `pre` ← 0.
  - start with load_val = 0 → ignored; stay in IDLE.
- RUN:
  - clear → IDLE; remain ← 0.
  - start → restart: remain ← load_val, `pre` ← 0, stay RUN. If load_val = 0 the start is ignored.
  - pause → PAUSE; `pre` keeps the value it reaches at the end of that cycle.
- PAUSE:
  - start → RUN, resuming with no reload.
  - clear → IDLE; remain ← 0.
- DONE:
  - start with load_val ≠ 0 → RUN with reload.
  - clear → IDLE.
  - remain stays 0.
- Tick event in the same cycle as clear or start: the command wins. No tick and no done are emitted.
- Tick event in the same cycle as pause: the tick is still emitted (tick_1Hz and decrement next cycle), and the state becomes PAUSE. If that tick reaches 0, the state becomes DONE instead of PAUSE.
- remain never underflows. It is not modified outside the rules above.
- rst_n low at any time (including mid-count or mid-pause) immediately forces:
  - state = IDLE, remain = 0, `pre` = 0;
  - tick_1Hz = 0, done = 0, running = 0.

## Timing
- All outputs are registered. running and state are decoded from the state register.
- Reset values: remain 0, tick_1Hz 0, done 0, running 0, state 0.
- Start pulse accepted in cycle N:
  - state = RUN and remain = load_val from cycle N+1.
  - Tick k is high in cycle N+1+k·TICK_DIV, with remain = load_val−k in that cycle.
  - done and the DONE state appear in cycle N+1+load_val·TICK_DIV, the same cycle as the final tick_1Hz.
- Pause pulse in cycle M followed by a start pulse in cycle R: every later tick is delayed by exactly R−M cycles.
- tick_1Hz and done are each high for exactly one cycle per event.

## Test plan
Directed scenarios use TICK_DIV=4, CNT_W=8, start pulse in cycle 0.
- load_val=3, start → tick_1Hz high in cycles 5, 9, 13 with remain 2, 1, 0; done high only in cycle 13; state=3 from cycle 13.
- load_val=3, start, pause in cycle 6, start in cycle 16 → state=2 in cycles 7–16; ticks in cycles 5, 19, 23; done in cycle 23.
- In RUN, assert clear and start in the same cycle → next cycle state=0, remain=0; no tick and no done afterwards.
- load_val=0, start in IDLE → state stays 0, remain stays 0, no done. Then load_val=2, start in DONE after a completed count → RUN, remain=2.
- Drop rst_n asynchronously mid-count (between clock edges, remain=2) → all outputs 0 and state=0 before the next clock edge. After release, no ticks occur until a new start.
- Tick event coinciding with pause → tick emitted and remain decremented, then state=2. With remain=1 in that case → done=1 and state=3.

Source files
------------

// File: rtl/countdown_timer_ctrl.sv
// Seconds countdown timer controller with a gated prescaler: the sub-second
// fraction survives pause/resume because the prescaler only advances in RUN.
module countdown_timer_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 8
) (
    input  logic             clk_50mHz,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    output logic [CNT_W-1:0] remain,
    output logic             tick_1Hz,
    output logic             done,
    output logic             running,
    output logic [1:0]       state
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_ZERO = {PRE_W{1'b0}};
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_remain;
    logic [PRE_W-1:0] r_pre;
    logic             r_tick;
    logic             r_done;

    logic [1:0]       w_state_nx;
    logic [CNT_W-1:0] w_remain_nx;
    logic [PRE_W-1:0] w_pre_nx;
    logic             w_tick_nx;
    logic             w_done_nx;
    logic             w_start_ok;
    logic             w_tick_ev;

    // A start with a zero load value is treated as no start at all.
    assign w_start_ok = start && (load_val != CNT_ZERO);
    assign w_tick_ev  = (r_state == ST_RUN) && (r_pre == PRE_MAX);

    // Next-state, counter and pulse decode; command priority clear > start > pause.
    always_comb begin
        w_state_nx  = r_state;
        w_remain_nx = r_remain;
        w_pre_nx    = r_pre;
        w_tick_nx   = 1'b0;
        w_done_nx   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_pre_nx = PRE_ZERO;
                if (!clear && w_start_ok) begin
                    w_state_nx  = ST_RUN;
                    w_remain_nx = load_val;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (clear) begin
                    w_state_nx  = ST_IDLE;
                    w_remain_nx = CNT_ZERO;
                    w_pre_nx    = PRE_ZERO;
                end else if (w_start_ok) begin
                    w_remain_nx = load_val;
                    w_pre_nx    = PRE_ZERO;
                end else if (w_tick_ev) begin
                    w_pre_nx  = PRE_ZERO;
                    w_tick_nx = 1'b1;
                    // Reaching zero overrides a coincident pause.
                    if (r_remain <= CNT_ONE) begin
                        w_remain_nx = CNT_ZERO;
                        w_done_nx   = 1'b1;
                        w_state_nx  = ST_DONE;
                    end else begin
                        w_remain_nx = r_remain - CNT_ONE;
                        w_state_nx  = pause ? ST_PAUSE : ST_RUN;
                    end
                end else begin
                    w_pre_nx   = r_pre + PRE_ONE;
                    w_state_nx = pause ? ST_PAUSE : ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (clear) begin
                    w_state_nx  = ST_IDLE;
                    w_remain_nx = CNT_ZERO;
                    w_pre_nx    = PRE_ZERO;
                end else if (start) begin
                    w_state_nx = ST_RUN;
                end else begin
                    w_state_nx = ST_PAUSE;
                end
            end
            ST_DONE: begin
                w_pre_nx = PRE_ZERO;
                if (clear) begin
                    w_state_nx = ST_IDLE;
                end else if (w_start_ok) begin
                    w_state_nx  = ST_RUN;
                    w_remain_nx = load_val;
                end else begin
                    w_state_nx = ST_DONE;
                end
            end
            default: begin
                w_state_nx  = ST_IDLE;
                w_remain_nx = CNT_ZERO;
                w_pre_nx    = PRE_ZERO;
            end
        endcase
    end

    // State, counters and output pulse registers.
    always_ff @(posedge clk_50mHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_remain <= CNT_ZERO;
            r_pre    <= PRE_ZERO;
            r_tick   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_remain <= w_remain_nx;
            r_pre    <= w_pre_nx;
            r_tick   <= w_tick_nx;
            r_done   <= w_done_nx;
        end
    end

    assign remain   = r_remain;
    assign tick_1Hz = r_tick;
    assign done     = r_done;
    assign state    = r_state;
    assign running  = (r_state == ST_RUN);

endmodule
